io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Sequences the CPU-side 8-bit peripheral I/O bus (`o_ioNCE`, `o_ioAddress`, `o_ioNOE`, `o_ioNWE`, shared data bus) and shares it between two requesters: the CPU core (port 0) and the debug/monitor unit (port 1). It converts single-cycle-held request handshakes into properly timed chip-enable, output-enable and write-enable strobes, with configurable setup, strobe and hold phases. It sits between the core/debug logic and the external I/O pins, on the `i_oszClk` domain.

## Interface
Parameters:
- `SETUP_CYCLES`, 1: cycles with `o_ioNCE` low and address valid before the strobe; range 1..15.
- `STROBE_CYCLES`, 2: cycles with `o_ioNOE` or `o_ioNWE` low; range 1..15.
- `HOLD_CYCLES`, 1: cycles with the strobe released but `o_ioNCE`, address and write data held; range 1..15.

Ports (clock and reset first):
- `i_oszClk`  in  1  system clock; all logic rising-edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_req[1:0]`  in  2  request per port; held high until that port's `o_done` bit.
- `i_we[1:0]`  in  2  per port: 1 = write, 0 = read; stable while `i_req` is high.
- `i_addr0`, `i_addr1`  in  8 each  per-port I/O address.
- `i_wdata0`, `i_wdata1`  in  8 each  per-port write data.
- `o_done[1:0]`  out  2  one-cycle completion pulse for the served port.
- `o_rdata`  out  8  read data; valid in the `o_done` cycle, held until the next read completes.
- `o_rdInvalid`  out  1  valid with `o_done`: the read saw `i_busNOE` high at capture.
- `o_busy`  out  1  high in SETUP, STROBE and HOLD.
- `o_ioNCE`, `o_ioNOE`, `o_ioNWE`  out  1 each  active-low I/O strobes.
- `o_ioAddress`  out  8  I/O address.
- `o_bus`  out  8  write data to the bus.
- `i_bus`  in  8  read data from the bus.
- `i_busNOE`  in  1  low = a peripheral is driving `i_bus`.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A single phase counter is loaded with N-1 on entry to each phase.
- **IDLE:** `o_ioNCE`, `o_ioNOE` and `o_ioNWE` are high. If any `i_req` bit is high and `o_done` is 0 this cycle, the arbiter picks a winner and moves to SETUP at the next edge.
  - On that edge it latches the winner's address, write data, `we` and port id.
- **Arbitration:** round-robin. Pointer `last` holds the port served most recently.
  - If both ports request, the port other than `last` wins.
  - If only one port requests, that port wins.
  - `last` updates when the winner is latched.
- **SETUP:** `o_ioNCE`=0; `o_ioAddress` is the latched address; `o_ioNOE` and `o_ioNWE` are high; `o_bus` carries the latched data on a write and 0 on a read.
- **STROBE:** as SETUP, plus `o_ioNWE`=0 for a write or `o_ioNOE`=0 for a read.
  - On the edge leaving STROBE on a read: capture `i_bus` into `o_rdata` and `i_busNOE` into a pending invalid flag.
  - If `i_busNOE`=1 at capture, `o_rdata` is loaded with 8'hFF.
- **HOLD:** strobes are high; `o_ioNCE`, address and `o_bus` are unchanged.
- **Leaving HOLD:** the FSM returns to IDLE. In the first IDLE cycle, `o_done[port]`=1 and `o_rdInvalid` shows the flag (0 for writes).
- **Minimum gap:** `o_done` blocks a new start in that cycle, so a port that deasserts `i_req` on seeing `o_done` is never served twice.
- **Request dropped early:** a request withdrawn mid-transaction is still completed and its `o_done` is still pulsed.
- **Strobe exclusivity:** `o_ioNOE` and `o_ioNWE` are never low at the same time. Neither is ever low while `o_ioNCE` is high.
- **Reset (asynchronous, effective immediately, including mid-transaction):**
  - state IDLE;
  - `o_ioNCE` = `o_ioNOE` = `o_ioNWE` = 1;
  - `o_ioAddress` = 0, `o_bus` = 0, `o_rdata` = 0;
  - `o_done` = 0, `o_rdInvalid` = 0, `o_busy` = 0;
  - `last` = 1, so port 0 wins the first tie.

## Timing
- All outputs are registered.
- Request seen in IDLE at edge E0:
  - SETUP occupies cycles E0+1 .. E0+S;
  - STROBE occupies the next T cycles;
  - HOLD occupies the next H cycles;
  - `o_done` is high in cycle E0+S+T+H+1.
- A transaction occupies S+T+H+2 cycles from the request being sampled to the next possible start. With defaults this is 6 cycles.
- Address and write data are stable from the first SETUP cycle through the last HOLD cycle. This gives S cycles of setup and H cycles of hold around the strobe.
- `o_busy` is high for exactly S+T+H cycles per transaction.

## Test plan
- **Single write (defaults):** port 0 writes 8'hA5 to 0x10.
  - `o_ioNCE` low for 4 cycles; `o_ioNWE` low in cycles 2–3 only; `o_ioAddress`=0x10 and `o_bus`=0xA5 throughout.
  - `o_done`=2'b01 exactly 5 cycles after request sampling; `o_ioNOE` stays high.
- **Read:** port 1 reads 0x03 with the bench driving `i_bus`=0x3C and `i_busNOE`=0.
  - `o_ioNOE` low for 2 cycles; `o_rdata`=0x3C and `o_rdInvalid`=0 when `o_done`=2'b10.
  - Repeat at address 0x00 with `i_busNOE`=1: `o_rdata`=0xFF and `o_rdInvalid`=1.
- **Contention:** both ports request continuously after reset.
  - Grant order is 0,1,0,1.
  - Each port deasserts `i_req` on its `o_done` and is never served twice in a row while the other is waiting.
- **Back-to-back on one port:** port 0 issues four writes, raising `i_req` again in the cycle after `o_done`.
  - Successive SETUP entries are spaced exactly 6 cycles apart.
- **Reset mid-strobe:** assert `i_reset` during STROBE of a write.
  - `o_ioNWE` and `o_ioNCE` go high without waiting for a clock edge; no `o_done` is pulsed.
  - After release, a pending port-0 request starts normally.
- **Parameter sweep:** S/T/H = 3/5/2 and 1/1/1.
  - Phase lengths match the parameters, and the `o_done` latency equals S+T+H+1.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Two-port round-robin sequencer for the 8-bit peripheral I/O bus (CE/OE/WE with setup/strobe/hold phases).
// Latency: o_done pulses S+T+H+1 cycles after the request is sampled; no backpressure, requests stay high until o_done.
module io_bus_arbiter #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       i_oszClk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic [1:0] i_we,
    input  logic [7:0] i_addr0,
    input  logic [7:0] i_addr1,
    input  logic [7:0] i_wdata0,
    input  logic [7:0] i_wdata1,
    output logic [1:0] o_done,
    output logic [7:0] o_rdata,
    output logic       o_rdInvalid,
    output logic       o_busy,
    output logic       o_ioNCE,
    output logic       o_ioNOE,
    output logic       o_ioNWE,
    output logic [7:0] o_ioAddress,
    output logic [7:0] o_bus,
    input  logic [7:0] i_bus,
    input  logic       i_busNOE
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_t     state, nextState;
    logic [3:0] cnt, nextCnt;
    logic       curPort, curWe, last, pendInv;
    logic       winner, startXfer, captureRd, finish;

    // Tie goes to the port not served last; a lone requester always wins.
    assign winner = (i_req == 2'b11) ? ~last : i_req[1];

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        startXfer = 1'b0;
        captureRd = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                // A done pulse in this cycle blocks a restart, so a port dropping req on done is not served twice.
                if ((|i_req) && (o_done == 2'b00)) begin
                    startXfer = 1'b1;
                    nextState = SETUP;
                    nextCnt   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    nextState = STROBE;
                    nextCnt   = STROBE_LOAD;
                end else begin
                    nextCnt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    nextState = HOLD;
                    nextCnt   = HOLD_LOAD;
                    captureRd = ~curWe;
                end else begin
                    nextCnt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    nextState = IDLE;
                    finish    = 1'b1;
                end else begin
                    nextCnt = cnt - 4'd1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_oszClk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            curPort     <= 1'b0;
            curWe       <= 1'b0;
            last        <= 1'b1;
            pendInv     <= 1'b0;
            o_ioAddress <= 8'h00;
            o_bus       <= 8'h00;
            o_rdata     <= 8'h00;
            o_done      <= 2'b00;
            o_rdInvalid <= 1'b0;
            o_busy      <= 1'b0;
            o_ioNCE     <= 1'b1;
            o_ioNOE     <= 1'b1;
            o_ioNWE     <= 1'b1;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (startXfer) begin
                curPort     <= winner;
                last        <= winner;
                curWe       <= i_we[winner];
                pendInv     <= 1'b0;
                o_ioAddress <= winner ? i_addr1 : i_addr0;
                o_bus       <= i_we[winner] ? (winner ? i_wdata1 : i_wdata0) : 8'h00;
            end
            if (captureRd) begin
                o_rdata <= i_busNOE ? 8'hFF : i_bus;
                pendInv <= i_busNOE;
            end
            o_done      <= finish ? (curPort ? 2'b10 : 2'b01) : 2'b00;
            o_rdInvalid <= finish & pendInv;
            o_busy      <= (nextState != IDLE);
            // curWe is already latched whenever STROBE is entered, since SETUP lasts at least one cycle.
            o_ioNCE     <= (nextState == IDLE);
            o_ioNWE     <= ~((nextState == STROBE) & curWe);
            o_ioNOE     <= ~((nextState == STROBE) & ~curWe);
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: default timing plus 3/5/2 and 1/1/1 instances sharing one stimulus.
module tb_io_bus_arbiter;

    logic       oszClk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] we = 2'b00;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
    logic [7:0] busIn = 8'h00;
    logic       busNOE = 1'b1;

    logic [1:0] done [3];
    logic [7:0] rdata [3];
    logic [7:0] ioAddr [3];
    logic [7:0] busOut [3];
    logic       rdInv [3];
    logic       busy [3];
    logic       nce [3];
    logic       noe [3];
    logic       nwe [3];

    int nCmp = 0;
    int nErr = 0;

    always #5 oszClk = ~oszClk;

    io_bus_arbiter #(.SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1)) uDef (
        .i_oszClk(oszClk), .i_reset(rst), .i_req(req), .i_we(we),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done(done[0]), .o_rdata(rdata[0]), .o_rdInvalid(rdInv[0]), .o_busy(busy[0]),
        .o_ioNCE(nce[0]), .o_ioNOE(noe[0]), .o_ioNWE(nwe[0]),
        .o_ioAddress(ioAddr[0]), .o_bus(busOut[0]), .i_bus(busIn), .i_busNOE(busNOE));

    io_bus_arbiter #(.SETUP_CYCLES(3), .STROBE_CYCLES(5), .HOLD_CYCLES(2)) uSlow (
        .i_oszClk(oszClk), .i_reset(rst), .i_req(req), .i_we(we),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done(done[1]), .o_rdata(rdata[1]), .o_rdInvalid(rdInv[1]), .o_busy(busy[1]),
        .o_ioNCE(nce[1]), .o_ioNOE(noe[1]), .o_ioNWE(nwe[1]),
        .o_ioAddress(ioAddr[1]), .o_bus(busOut[1]), .i_bus(busIn), .i_busNOE(busNOE));

    io_bus_arbiter #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) uFast (
        .i_oszClk(oszClk), .i_reset(rst), .i_req(req), .i_we(we),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done(done[2]), .o_rdata(rdata[2]), .o_rdInvalid(rdInv[2]), .o_busy(busy[2]),
        .o_ioNCE(nce[2]), .o_ioNOE(noe[2]), .o_ioNWE(nwe[2]),
        .o_ioAddress(ioAddr[2]), .o_bus(busOut[2]), .i_bus(busIn), .i_busNOE(busNOE));

    // Strobe exclusivity on the default instance, checked every cycle outside reset.
    always @(negedge oszClk) begin
        if (!rst) begin
            nCmp++;
            if ((!noe[0] && !nwe[0]) || (nce[0] && (!noe[0] || !nwe[0]))) begin
                nErr++;
                $display("FAIL strobe_excl: nce=%b noe=%b nwe=%b", nce[0], noe[0], nwe[0]);
            end
        end
    end

    // Starts and ends just after a falling edge.
    task automatic apply_reset();
        rst = 1'b1; req = 2'b00; we = 2'b00; busNOE = 1'b1; busIn = 8'h00;
        repeat (2) @(negedge oszClk);
        rst = 1'b0;
    endtask

    // Runs one transaction on one port and measures phases as seen by instance idx.
    task automatic do_xfer(input int idx, input bit port, input bit isWr,
                           input logic [7:0] a, input logic [7:0] d,
                           output int setupN, output int noeN, output int nweN,
                           output int holdN, output int lat,
                           output logic [1:0] doneVal, output logic inv, output logic [7:0] rd);
        bit sawStrobe;
        setupN = 0; noeN = 0; nweN = 0; holdN = 0; lat = -1;
        doneVal = 2'b00; inv = 1'b0; rd = 8'h00; sawStrobe = 1'b0;
        we = isWr ? 2'b11 : 2'b00;
        if (port) begin addr1 = a; wdata1 = d; req = 2'b10; end
        else      begin addr0 = a; wdata0 = d; req = 2'b01; end
        for (int k = 1; k <= 60; k++) begin
            @(negedge oszClk);
            if (!nce[idx]) begin
                if (!noe[idx]) begin noeN++; sawStrobe = 1'b1; end
                else if (!nwe[idx]) begin nweN++; sawStrobe = 1'b1; end
                else if (sawStrobe) holdN++;
                else setupN++;
            end
            if (done[idx] != 2'b00) begin
                lat = k; doneVal = done[idx]; inv = rdInv[idx]; rd = rdata[idx];
                break;
            end
        end
        req = 2'b00;
        @(negedge oszClk);
    endtask

    task automatic test_reset();
        @(negedge oszClk);
        rst = 1'b1;
        #1;
        nCmp++;
        if ({nce[0], noe[0], nwe[0], busy[0], done[0], rdInv[0]} !== 7'b1110000) begin
            nErr++;
            $display("FAIL reset_ctl: got %b want 1110000", {nce[0], noe[0], nwe[0], busy[0], done[0], rdInv[0]});
        end
        nCmp++;
        if ({ioAddr[0], busOut[0], rdata[0]} !== 24'h000000) begin
            nErr++;
            $display("FAIL reset_data: got %h want 000000", {ioAddr[0], busOut[0], rdata[0]});
        end
        apply_reset();
    endtask

    task automatic test_write();
        logic [5:0] expCtl;
        apply_reset();
        we = 2'b01; addr0 = 8'h10; wdata0 = 8'hA5; req = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            @(negedge oszClk);
            // {nce, noe, nwe, busy, done}
            expCtl = {!(k <= 4), 1'b1, !(k == 2 || k == 3), (k <= 4), (k == 5) ? 2'b01 : 2'b00};
            nCmp++;
            if ({nce[0], noe[0], nwe[0], busy[0], done[0]} !== expCtl) begin
                nErr++;
                $display("FAIL write_ctl k=%0d: got %b want %b", k, {nce[0], noe[0], nwe[0], busy[0], done[0]}, expCtl);
            end
            if (k <= 4) begin
                nCmp++;
                if ({ioAddr[0], busOut[0]} !== 16'h10A5) begin
                    nErr++;
                    $display("FAIL write_bus k=%0d: got %h want 10a5", k, {ioAddr[0], busOut[0]});
                end
            end
            if (done[0] != 2'b00) req = 2'b00;
        end
    endtask

    task automatic test_read();
        int s, o, w, h, lat;
        logic [1:0] dv;
        logic inv;
        logic [7:0] rd;
        apply_reset();
        busIn = 8'h3C; busNOE = 1'b0;
        do_xfer(0, 1'b1, 1'b0, 8'h03, 8'h00, s, o, w, h, lat, dv, inv, rd);
        nCmp++;
        if ({o, w, lat} !== {32'd2, 32'd0, 32'd5}) begin
            nErr++;
            $display("FAIL read_timing: got noe=%0d nwe=%0d lat=%0d want 2 0 5", o, w, lat);
        end
        nCmp++;
        if ({dv, rd, inv} !== {2'b10, 8'h3C, 1'b0}) begin
            nErr++;
            $display("FAIL read_ok: got done=%b rdata=%h inv=%b want 10 3c 0", dv, rd, inv);
        end
        busNOE = 1'b1;
        do_xfer(0, 1'b1, 1'b0, 8'h00, 8'h00, s, o, w, h, lat, dv, inv, rd);
        nCmp++;
        if ({dv, rd, inv} !== {2'b10, 8'hFF, 1'b1}) begin
            nErr++;
            $display("FAIL read_invalid: got done=%b rdata=%h inv=%b want 10 ff 1", dv, rd, inv);
        end
        busNOE = 1'b0;
    endtask

    task automatic test_contention();
        logic [1:0] seq [4];
        logic [1:0] expSeq [4];
        int n;
        expSeq[0] = 2'b01; expSeq[1] = 2'b10; expSeq[2] = 2'b01; expSeq[3] = 2'b10;
        n = 0;
        apply_reset();
        we = 2'b11; addr0 = 8'h20; addr1 = 8'h21; wdata0 = 8'h11; wdata1 = 8'h22;
        req = 2'b11;
        for (int t = 0; t < 200 && n < 4; t++) begin
            @(negedge oszClk);
            if (done[0] != 2'b00) begin seq[n] = done[0]; n++; end
            req = ~done[0];
        end
        req = 2'b00;
        nCmp++;
        if (n != 4) begin
            nErr++;
            $display("FAIL contention_count: got %0d grants want 4", n);
        end
        for (int i = 0; i < n; i++) begin
            nCmp++;
            if (seq[i] !== expSeq[i]) begin
                nErr++;
                $display("FAIL contention_order[%0d]: got %b want %b", i, seq[i], expSeq[i]);
            end
        end
        @(negedge oszClk);
    endtask

    task automatic test_back_to_back();
        int starts [4];
        int n, dones;
        logic prevNce;
        n = 0; dones = 0; prevNce = 1'b1;
        apply_reset();
        we = 2'b01; addr0 = 8'h30; wdata0 = 8'h40; req = 2'b01;
        for (int t = 0; t < 200 && dones < 4; t++) begin
            @(negedge oszClk);
            if (prevNce && !nce[0] && n < 4) begin starts[n] = t; n++; end
            prevNce = nce[0];
            if (done[0][0]) begin
                dones++;
                req = 2'b00;
                wdata0 = wdata0 + 8'h01;
            end else begin
                req = (dones < 4) ? 2'b01 : 2'b00;
            end
        end
        req = 2'b00;
        nCmp++;
        if (n != 4) begin
            nErr++;
            $display("FAIL b2b_count: got %0d starts want 4", n);
        end
        for (int i = 1; i < n; i++) begin
            nCmp++;
            if (starts[i] - starts[i-1] != 6) begin
                nErr++;
                $display("FAIL b2b_gap[%0d]: got %0d want 6", i, starts[i] - starts[i-1]);
            end
        end
        @(negedge oszClk);
    endtask

    task automatic test_reset_mid_strobe();
        bit found;
        found = 1'b0;
        apply_reset();
        we = 2'b01; addr0 = 8'h40; wdata0 = 8'h77; req = 2'b01;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge oszClk);
            if (!nwe[0]) found = 1'b1;
        end
        nCmp++;
        if (!found) begin
            nErr++;
            $display("FAIL midrst_strobe: got no write strobe want one");
        end
        #2 rst = 1'b1;
        #1;
        nCmp++;
        if ({nce[0], nwe[0], busy[0]} !== 3'b110) begin
            nErr++;
            $display("FAIL midrst_async: got nce/nwe/busy=%b want 110", {nce[0], nwe[0], busy[0]});
        end
        for (int t = 0; t < 2; t++) begin
            @(negedge oszClk);
            nCmp++;
            if (done[0] !== 2'b00) begin
                nErr++;
                $display("FAIL midrst_nodone: got %b want 00", done[0]);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge oszClk);
            if (k == 1) begin
                nCmp++;
                if (nce[0] !== 1'b0) begin
                    nErr++;
                    $display("FAIL midrst_restart: got nce=%b want 0", nce[0]);
                end
            end
            nCmp++;
            if (done[0] !== ((k == 5) ? 2'b01 : 2'b00)) begin
                nErr++;
                $display("FAIL midrst_done k=%0d: got %b want %b", k, done[0], (k == 5) ? 2'b01 : 2'b00);
            end
        end
        req = 2'b00;
        @(negedge oszClk);
    endtask

    task automatic test_param_sweep();
        int s, o, w, h, lat;
        logic [1:0] dv;
        logic inv;
        logic [7:0] rd;
        apply_reset();
        do_xfer(1, 1'b0, 1'b1, 8'h55, 8'hAA, s, o, w, h, lat, dv, inv, rd);
        nCmp++;
        if ({s, w, h, lat, o} !== {32'd3, 32'd5, 32'd2, 32'd11, 32'd0} || dv !== 2'b01) begin
            nErr++;
            $display("FAIL sweep_352: got s=%0d t=%0d h=%0d lat=%0d noe=%0d done=%b want 3 5 2 11 0 01", s, w, h, lat, o, dv);
        end
        apply_reset();
        do_xfer(2, 1'b0, 1'b1, 8'h66, 8'hBB, s, o, w, h, lat, dv, inv, rd);
        nCmp++;
        if ({s, w, h, lat, o} !== {32'd1, 32'd1, 32'd1, 32'd4, 32'd0} || dv !== 2'b01) begin
            nErr++;
            $display("FAIL sweep_111: got s=%0d t=%0d h=%0d lat=%0d noe=%0d done=%b want 1 1 1 4 0 01", s, w, h, lat, o, dv);
        end
        apply_reset();
        busIn = 8'h5A; busNOE = 1'b0;
        do_xfer(1, 1'b1, 1'b0, 8'h07, 8'h00, s, o, w, h, lat, dv, inv, rd);
        nCmp++;
        if ({s, o, h, lat} !== {32'd3, 32'd5, 32'd2, 32'd11} || {dv, rd} !== {2'b10, 8'h5A}) begin
            nErr++;
            $display("FAIL sweep_352_rd: got s=%0d t=%0d h=%0d lat=%0d done=%b rdata=%h want 3 5 2 11 10 5a", s, o, h, lat, dv, rd);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_strobe();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
